// File: rtl/hfrv_trace_pkg.sv
// Shared types for the HF-RISCV retire trace buffer: FSM states, record layout
// and the record-width helper used by the interface, RAM and top level.
package hfrv_trace_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DRAIN = 2'd3
   } trace_state_t;

   localparam int TRACE_DATA_W = 32;

   // Field order matches the packed rd_data word: {pc, instr, rd, we, wdata}.
   typedef struct packed {
      logic [TRACE_DATA_W-1:0] pc;
      logic [TRACE_DATA_W-1:0] instr;
      logic [4:0]              rd;
      logic                    we;
      logic [TRACE_DATA_W-1:0] wdata;
   } trace_rec_t;

   function automatic int rec_w(input int data_w);
      return 3 * data_w + 6;
   endfunction

endpackage

// File: rtl/hfrv_trace_buffer_if.sv
// Control, capture and drain signals of the trace buffer. The buffer uses the
// slave view; whoever drives retire/trigger inputs and consumes records is master.
interface hfrv_trace_buffer_if #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 64,
   parameter int NUM_TRIG = 2
);
   import hfrv_trace_pkg::*;

   localparam int REC_W = rec_w(DATA_W);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                       arm;
   logic                       abort;
   logic                       trig_ext;
   logic [NUM_TRIG-1:0]        trig_en;
   logic [NUM_TRIG*DATA_W-1:0] trig_pc;
   logic                       cap_valid;
   logic [DATA_W-1:0]          cap_pc;
   logic [DATA_W-1:0]          cap_instr;
   logic [4:0]                 cap_rd;
   logic                       cap_we;
   logic [DATA_W-1:0]          cap_wdata;
   logic                       rd_valid;
   logic                       rd_ready;
   logic [REC_W-1:0]           rd_data;
   logic [1:0]                 state;
   logic [CNT_W-1:0]           count;

   modport master (
      output arm, abort, trig_ext, trig_en, trig_pc,
      output cap_valid, cap_pc, cap_instr, cap_rd, cap_we, cap_wdata,
      output rd_ready,
      input  rd_valid, rd_data, state, count
   );

   modport slave (
      input  arm, abort, trig_ext, trig_en, trig_pc,
      input  cap_valid, cap_pc, cap_instr, cap_rd, cap_we, cap_wdata,
      input  rd_ready,
      output rd_valid, rd_data, state, count
   );

endinterface

// File: rtl/hfrv_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module hfrv_trace_ram #(
   parameter int DEPTH = 64,
   parameter int REC_W = 102
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [REC_W-1:0]         wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [REC_W-1:0]         rdata_o
);

   logic [REC_W-1:0] mem_q [DEPTH];
   logic [REC_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/hfrv_trace_buffer.sv
// Retire trace buffer: records into a circular RAM once armed, freezes a
// post-trigger window and then drains it oldest-first over valid/ready.
module hfrv_trace_buffer
   import hfrv_trace_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 64,
   parameter int POST_TRIG = 16,
   parameter int NUM_TRIG  = 2
) (
   input logic                clk,
   input logic                rst_n,
   hfrv_trace_buffer_if.slave bus
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam int REC_W = rec_w(DATA_W);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] POST_CNT = CNT_W'(POST_TRIG);

   trace_state_t     state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] post_cnt_q, post_cnt_d;
   logic             wrapped_q, wrapped_d;
   logic             rd_valid_q, rd_valid_d;

   logic                wr_en;
   logic                rd_en;
   logic [AW-1:0]       rd_addr;
   logic                enter_drain;
   logic [REC_W-1:0]    wr_rec;
   logic [REC_W-1:0]    rd_rec;
   logic [NUM_TRIG-1:0] pc_match;
   logic                hit;

   for (genvar i = 0; i < NUM_TRIG; i++) begin : g_cmp
      assign pc_match[i] = bus.trig_en[i] && (bus.cap_pc == bus.trig_pc[i*DATA_W +: DATA_W]);
   end

   assign hit    = bus.cap_valid && (bus.trig_ext || (|pc_match));
   assign wr_rec = {bus.cap_pc, bus.cap_instr, bus.cap_rd, bus.cap_we, bus.cap_wdata};

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      post_cnt_d  = post_cnt_q;
      wrapped_d   = wrapped_q;
      rd_valid_d  = rd_valid_q;
      enter_drain = 1'b0;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      rd_addr     = rd_ptr_q;

      unique case (state_q)
         IDLE: begin
            if (bus.arm) begin
               state_d   = ARMED;
               wr_ptr_d  = '0;
               count_d   = '0;
               wrapped_d = 1'b0;
            end
         end

         ARMED, POST: begin
            if (bus.cap_valid) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (count_q == FULL_CNT) wrapped_d = 1'b1;
               else                     count_d   = count_q + 1'b1;

               if (state_q == ARMED) begin
                  if (hit) begin
                     if (POST_TRIG == 0) begin
                        enter_drain = 1'b1;
                     end else begin
                        post_cnt_d = POST_CNT;
                        state_d    = POST;
                     end
                  end
               end else begin
                  post_cnt_d  = post_cnt_q - 1'b1;
                  enter_drain = (post_cnt_q == CNT_W'(1));
               end

               // Once wrapped, the slot after the newest record holds the oldest one.
               if (enter_drain) begin
                  state_d  = DRAIN;
                  rd_ptr_d = wrapped_d ? wr_ptr_d : '0;
               end
            end
         end

         DRAIN: begin
            if (!rd_valid_q) begin
               if (count_q != '0) begin
                  rd_valid_d = 1'b1;
                  rd_en      = 1'b1;
                  rd_addr    = rd_ptr_q;
               end else begin
                  state_d = IDLE;
               end
            end else if (bus.rd_ready) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
               count_d  = count_q - 1'b1;
               if (count_q == CNT_W'(1)) begin
                  rd_valid_d = 1'b0;
                  state_d    = IDLE;
               end else begin
                  rd_en   = 1'b1;
                  rd_addr = rd_ptr_d;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      if (bus.abort) begin
         state_d    = IDLE;
         count_d    = '0;
         rd_valid_d = 1'b0;
         wr_en      = 1'b0;
         rd_en      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         post_cnt_q <= '0;
         wrapped_q  <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         post_cnt_q <= post_cnt_d;
         wrapped_q  <= wrapped_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   hfrv_trace_ram #(
      .DEPTH (DEPTH),
      .REC_W (REC_W)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_rec),
      .re_i    (rd_en),
      .raddr_i (rd_addr),
      .rdata_o (rd_rec)
   );

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_rec;
   assign bus.state    = state_q;
   assign bus.count    = count_q;

endmodule

// File: tb/tb_hfrv_trace_buffer.sv
// Randomised bench for hfrv_trace_buffer: two instances (POST_TRIG=4/DEPTH=64 and
// POST_TRIG=0/DEPTH=16) checked against a queue model of the captured window.
module tb_hfrv_trace_buffer;
   import hfrv_trace_pkg::*;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        arm = 0, abort = 0, trig_ext = 0, cap_valid = 0, cap_we = 0, rd_ready = 0;
   logic [1:0]  trig_en = '0;
   logic [63:0] trig_pc = '0;
   logic [31:0] cap_pc = '0, cap_instr = '0, cap_wdata = '0;
   logic [4:0]  cap_rd = '0;
   int          sel = 0;

   hfrv_trace_buffer_if #(.DATA_W(32), .DEPTH(64), .NUM_TRIG(2)) if_a ();
   hfrv_trace_buffer_if #(.DATA_W(32), .DEPTH(16), .NUM_TRIG(2)) if_b ();

   hfrv_trace_buffer #(.DATA_W(32), .DEPTH(64), .POST_TRIG(4), .NUM_TRIG(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a));
   hfrv_trace_buffer #(.DATA_W(32), .DEPTH(16), .POST_TRIG(0), .NUM_TRIG(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b));

   // Strobes reach only the selected instance; data buses are shared.
   assign if_a.arm       = arm && (sel == 0);
   assign if_a.abort     = abort && (sel == 0);
   assign if_a.cap_valid = cap_valid && (sel == 0);
   assign if_a.rd_ready  = rd_ready && (sel == 0);
   assign if_a.trig_ext  = trig_ext;
   assign if_a.trig_en   = trig_en;
   assign if_a.trig_pc   = trig_pc;
   assign if_a.cap_pc    = cap_pc;
   assign if_a.cap_instr = cap_instr;
   assign if_a.cap_rd    = cap_rd;
   assign if_a.cap_we    = cap_we;
   assign if_a.cap_wdata = cap_wdata;
   assign if_b.arm       = arm && (sel == 1);
   assign if_b.abort     = abort && (sel == 1);
   assign if_b.cap_valid = cap_valid && (sel == 1);
   assign if_b.rd_ready  = rd_ready && (sel == 1);
   assign if_b.trig_ext  = trig_ext;
   assign if_b.trig_en   = trig_en;
   assign if_b.trig_pc   = trig_pc;
   assign if_b.cap_pc    = cap_pc;
   assign if_b.cap_instr = cap_instr;
   assign if_b.cap_rd    = cap_rd;
   assign if_b.cap_we    = cap_we;
   assign if_b.cap_wdata = cap_wdata;

   logic [1:0]   o_state;
   logic [31:0]  o_count;
   logic         o_vld;
   logic [101:0] o_data;
   assign o_state = (sel == 1) ? if_b.state : if_a.state;
   assign o_count = (sel == 1) ? 32'(if_b.count) : 32'(if_a.count);
   assign o_vld   = (sel == 1) ? if_b.rd_valid : if_a.rd_valid;
   assign o_data  = (sel == 1) ? if_b.rd_data : if_a.rd_data;

   int n_tests = 0;
   int n_fail  = 0;
   trace_rec_t exp_q[$];

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_state"}, 128'(o_state), 128'(0));
      check_eq({tag, "_count"}, 128'(o_count), 128'(0));
      check_eq({tag, "_vld"}, 128'(o_vld), 128'(0));
   endtask

   // Arm, feed records pc=BASE+4k, trigger on record t; the model keeps the
   // newest DEPTH of records 0..t+post. abort_at >= 0 aborts on that record.
   task automatic run_capture(input int s, input int t, input bit use_ext,
                              input int extra, input int abort_at);
      int depth, post, last, c, es;
      trace_rec_t r;
      sel   = s;
      depth = (s == 0) ? 64 : 16;
      post  = (s == 0) ? 4 : 0;
      last  = t + post;
      exp_q.delete();
      c       = $urandom_range(0, 1);
      trig_en = '0;
      trig_pc = {32'h1000_0000, 32'h1000_0000};
      if (!use_ext) begin
         trig_pc[c*32 +: 32] = 32'(BASE + 4 * t);
         trig_en[c] = 1'b1;
      end
      if (t > 0) trig_pc[(1-c)*32 +: 32] = 32'(BASE + 4 * $urandom_range(0, t - 1));
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check_eq("arm_state", 128'(o_state), 128'(1));
      check_eq("arm_count", 128'(o_count), 128'(0));
      for (int k = 0; k <= last + extra; k++) begin
         if (k <= last) begin
            repeat ($urandom_range(0, 2)) begin
               cap_valid = 1'b0;
               trig_ext  = 1'($urandom);
               cap_pc    = 32'(BASE + 4 * t);
               tick();
            end
         end
         r.pc      = 32'(BASE + 4 * k);
         r.instr   = $urandom;
         r.rd      = 5'($urandom);
         r.we      = 1'($urandom);
         r.wdata   = $urandom;
         cap_valid = 1'b1;
         cap_pc    = r.pc;
         cap_instr = r.instr;
         cap_rd    = r.rd;
         cap_we    = r.we;
         cap_wdata = r.wdata;
         trig_ext  = use_ext ? (k == t) : 1'b0;
         if (k > t) trig_ext = 1'($urandom);
         arm   = ($urandom_range(0, 7) == 0);
         abort = (k == abort_at);
         if (k <= last) begin
            exp_q.push_back(r);
            if (exp_q.size() > depth) void'(exp_q.pop_front());
         end
         tick();
         arm = 1'b0;
         if (abort) begin
            abort = 1'b0;
            cap_valid = 1'b0;
            check_idle("abort_cap");
            exp_q.delete();
            return;
         end
         es = (k < t) ? 1 : ((k < last) ? 2 : 3);
         check_eq("cap_state", 128'(o_state), 128'(es));
         check_eq("cap_count", 128'(o_count), 128'(exp_q.size()));
         if (k == last)     check_eq("drain_lat0", 128'(o_vld), 128'(0));
         if (k == last + 1) check_eq("drain_lat1", 128'(o_vld), 128'(1));
      end
      cap_valid = 1'b0;
      trig_ext  = 1'b0;
   endtask

   // mode 0 random ready, 1 ready held high, 2 ready pattern 1,0,0,1.
   // cut >= 0 interrupts after that many transfers (kind 0 abort, 1 async reset).
   task automatic run_drain(input int mode, input int cut, input int cut_kind);
      int budget = 0, i = 0, xfers = 0;
      bit stalled = 0;
      logic [101:0] held = '0;
      while (exp_q.size() > 0 && budget < 400) begin
         if (xfers == cut) begin
            if (cut_kind == 1) begin
               @(negedge clk);
               rst_n = 1'b0;
               #1;
               check_idle("rst_drn");
               @(posedge clk);
               #1;
               rst_n = 1'b1;
            end else begin
               abort    = 1'b1;
               rd_ready = 1'($urandom);
               tick();
               abort = 1'b0;
               check_idle("abort_drn");
            end
            rd_ready = 1'b0;
            exp_q.delete();
            return;
         end
         check_eq("drn_vld", 128'(o_vld), 128'(1));
         check_eq("drn_count", 128'(o_count), 128'(exp_q.size()));
         if (stalled) check_eq("drn_hold", 128'(o_data), 128'(held));
         case (mode)
            0:       rd_ready = 1'($urandom);
            1:       rd_ready = 1'b1;
            default: rd_ready = (i % 4 == 0) || (i % 4 == 3);
         endcase
         i++;
         if (rd_ready && o_vld) begin
            check_eq("drn_data", 128'(o_data), 128'(exp_q.pop_front()));
            xfers++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held    = o_data;
         end
         tick();
         budget++;
      end
      rd_ready = 1'b0;
      check_eq("drn_left", 128'(exp_q.size()), 128'(0));
      check_idle("drn_end");
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #1;
         check_idle("reset");
         check_eq("reset_data", 128'(o_data), 128'(0));
      end
      rst_n = 1'b1;
      sel   = 0;
      tick();

      // Retire traffic without arm must not start capture.
      for (int k = 0; k < 10; k++) begin
         cap_valid = 1'b1;
         cap_pc    = 32'(BASE + 4 * k);
         trig_ext  = 1'($urandom);
         tick();
         check_idle("noarm");
      end
      cap_valid = 1'b0;
      trig_ext  = 1'b0;

      // Arm and abort together in IDLE: abort wins.
      arm   = 1'b1;
      abort = 1'b1;
      tick();
      arm   = 1'b0;
      abort = 1'b0;
      check_idle("arm_abort");

      run_capture(0, 16, 0, 2, -1);  run_drain(1, -1, 0);   // before wrap, 21 records
      run_capture(0, 90, 0, 1, -1);  run_drain(2, -1, 0);   // after wrap, records 31..94
      run_capture(0, 59, 1, 2, -1);  run_drain(0, -1, 0);   // exactly DEPTH, no overwrite
      run_capture(1, 5, 1, 1, -1);   run_drain(0, -1, 0);   // POST_TRIG=0, 6 records
      run_capture(1, 0, 0, 2, -1);   run_drain(2, -1, 0);   // single record
      run_capture(1, 30, 1, 3, -1);  run_drain(1, -1, 0);   // wrapped, 16 records
      run_capture(0, 10, 0, 1, 12);                         // abort in POST
      run_capture(0, 3, 0, 1, -1);   run_drain(0, 2, 0);    // restart, abort mid-drain
      run_capture(0, 7, 1, 1, -1);   run_drain(2, -1, 0);
      run_capture(0, 8, 0, 1, -1);   run_drain(1, 3, 1);    // async reset mid-drain
      run_capture(0, 5, 0, 1, -1);   run_drain(0, -1, 0);

      for (int n = 0; n < 6; n++) begin
         int s;
         s = $urandom_range(0, 1);
         run_capture(s, $urandom_range(0, (s == 0) ? 100 : 40), 1'($urandom), $urandom_range(1, 3), -1);
         run_drain($urandom_range(0, 2), -1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
